cache_fill_fsm: RTL and testbench

Parametrised miss-handling controller for the cache level that sits between the pipelined core's IF/MEM stages and the shared multi-cycle main memory. On a miss it fetches a whole block, issuing one word request per accepted handshake. It writes each returned word into the cache data array and finishes with one tag-array write. While busy it holds the pipeline stalled through `fsm_busy`.

---
 rtl/cache_fill_pkg.sv | 29 ++
 rtl/wrap_cnt.sv | 28 ++
 rtl/cache_fill_fsm.sv | 132 +++++++++++++
 tb/tb_cache_fill_fsm.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/cache_fill_pkg.sv
// rtl/cache_fill_pkg.sv - shared types, widths and offset helper for the cache fill controller
// Purpose: state encoding, default-configuration widths and the modulo offset add
//          used by cache_fill_fsm and wrap_cnt.
// Contents:
//   fill_state_t - IDLE / FILL / TAG
//   OFF_W        - word-offset width for the default block size
//   BYTE_OFF_W   - byte-offset width (word offset plus the 2-byte word lane bit)
//   off_add      - (a + b) mod n for power-of-two n
package cache_fill_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    TAG  = 2'd2
  } fill_state_t;

  localparam int DEF_WORDS_PER_BLOCK = 8;
  localparam int OFF_W               = $clog2(DEF_WORDS_PER_BLOCK);
  localparam int BYTE_OFF_W          = OFF_W + 1;

  // n is a power of two, so masking is the modulo; the result never carries
  // out of the block offset field.
  function automatic logic [31:0] off_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] n);
    return (a + b) & (n - 32'd1);
  endfunction

endpackage

// File: rtl/wrap_cnt.sv
// rtl/wrap_cnt.sv - clearable, enable-gated up counter
// Purpose: issue / receive word counters of the fill controller.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   clr        - synchronous clear (wins over en)
//   en         - count enable
//   cnt        - current count, W bits
module wrap_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/cache_fill_fsm.sv
// rtl/cache_fill_fsm.sv - cache miss block-fill controller
// Purpose: on a miss, request every word of the block from main memory, write each
//          returned word into the data array, then write the tag once. Stalls the
//          pipeline through fsm_busy while active.
// Optional feature: CACHE_CRITICAL_WORD_FIRST_EN - when defined the missed word is
//          requested first and requests wrap through the block; otherwise words are
//          requested in ascending order from the block base.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   miss_detected       - miss request, sampled in IDLE only
//   miss_address        - byte address of the missing access
//   mem_ready           - memory accepts a request this cycle
//   memory_data_valid   - returned word valid (in request order)
//   memory_data         - returned word
//   fsm_busy            - pipeline stall
//   mem_req             - read request
//   memory_address      - request byte address
//   write_data_array    - data-array write strobe
//   fill_word_index     - data-array word slot being written
//   fill_data           - pass-through of memory_data
//   write_tag_array     - tag/valid write strobe
//   fill_base           - latched block base address
module cache_fill_fsm
  import cache_fill_pkg::*;
#(
  parameter int ADDR_W          = 16,
  parameter int DATA_W          = 16,
  parameter int WORDS_PER_BLOCK = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               miss_detected,
  input  logic [ADDR_W-1:0]                  miss_address,
  input  logic                               mem_ready,
  input  logic                               memory_data_valid,
  input  logic [DATA_W-1:0]                  memory_data,
  output logic                               fsm_busy,
  output logic                               mem_req,
  output logic [ADDR_W-1:0]                  memory_address,
  output logic                               write_data_array,
  output logic [$clog2(WORDS_PER_BLOCK)-1:0] fill_word_index,
  output logic [DATA_W-1:0]                  fill_data,
  output logic                               write_tag_array,
  output logic [ADDR_W-1:0]                  fill_base
);

  localparam int IDX_W = $clog2(WORDS_PER_BLOCK);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0]  N_CNT     = CNT_W'(WORDS_PER_BLOCK);
  localparam logic [ADDR_W-1:0] BASE_MASK = ~ADDR_W'(2 * WORDS_PER_BLOCK - 1);

  fill_state_t        state_q, state_d;
  logic [IDX_W-1:0]   start_off_q, start_off_d;
  logic [CNT_W-1:0]   icnt, rcnt;
  logic               miss_take, issue, accept;
  logic [IDX_W-1:0]   req_off, wr_off;

`ifdef CACHE_CRITICAL_WORD_FIRST_EN
  assign start_off_d = miss_address[IDX_W:1];
`else
  assign start_off_d = '0;
`endif

  assign miss_take = (state_q == IDLE) && miss_detected;
  assign issue     = (state_q == FILL) && (icnt < N_CNT) && mem_ready;
  // Uses the pre-edge icnt: a return can only match a request already issued.
  assign accept    = (state_q == FILL) && memory_data_valid && (rcnt < icnt);

  assign req_off   = IDX_W'(off_add(32'(start_off_q), 32'(icnt), 32'(WORDS_PER_BLOCK)));
  assign wr_off    = IDX_W'(off_add(32'(start_off_q), 32'(rcnt), 32'(WORDS_PER_BLOCK)));
  assign fill_data = memory_data;

  wrap_cnt #(.W(CNT_W)) u_issue_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (miss_take),
    .en    (issue),
    .cnt   (icnt)
  );

  wrap_cnt #(.W(CNT_W)) u_recv_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (miss_take),
    .en    (accept),
    .cnt   (rcnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      fill_base   <= '0;
      start_off_q <= '0;
    end else begin
      state_q <= state_d;
      if (miss_take) begin
        fill_base   <= miss_address & BASE_MASK;
        start_off_q <= start_off_d;
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    fsm_busy         = 1'b0;
    mem_req          = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    fill_word_index  = '0;
    write_tag_array  = 1'b0;
    case (state_q)
      IDLE: begin
        if (miss_detected) state_d = FILL;
      end
      FILL: begin
        fsm_busy         = 1'b1;
        mem_req          = (icnt < N_CNT);
        memory_address   = fill_base + ADDR_W'({req_off, 1'b0});
        write_data_array = accept;
        fill_word_index  = wr_off;
        if (accept && (rcnt == N_CNT - CNT_W'(1))) state_d = TAG;
      end
      TAG: begin
        fsm_busy        = 1'b1;
        write_tag_array = 1'b1;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb/tb_cache_fill_fsm.sv - self-checking bench for cache_fill_fsm
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        miss = 1'b0;
  logic [15:0] maddr = '0;
  logic        ready = 1'b0;
  logic        valid = 1'b0;
  logic [15:0] mdata = '0;
  logic        sel = 1'b0;

  logic        b_busy, b_req, b_wda, b_wta;
  logic [15:0] b_addr, b_fd, b_base;
  logic [2:0]  b_idx;
  logic        s_busy, s_req, s_wda, s_wta;
  logic [15:0] s_addr, s_fd, s_base;
  logic [1:0]  s_idx;

  logic        o_busy, o_req, o_wda, o_wta;
  logic [15:0] o_addr, o_fd, o_base;
  logic [2:0]  o_idx;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cache_fill_fsm #(.ADDR_W(16), .DATA_W(16), .WORDS_PER_BLOCK(8)) u_dut (
    .clk (clk), .rst_n (rst_n),
    .miss_detected (miss & ~sel), .miss_address (maddr),
    .mem_ready (ready), .memory_data_valid (valid), .memory_data (mdata),
    .fsm_busy (b_busy), .mem_req (b_req), .memory_address (b_addr),
    .write_data_array (b_wda), .fill_word_index (b_idx), .fill_data (b_fd),
    .write_tag_array (b_wta), .fill_base (b_base)
  );

  cache_fill_fsm #(.ADDR_W(16), .DATA_W(16), .WORDS_PER_BLOCK(4)) u_dut4 (
    .clk (clk), .rst_n (rst_n),
    .miss_detected (miss & sel), .miss_address (maddr),
    .mem_ready (ready), .memory_data_valid (valid), .memory_data (mdata),
    .fsm_busy (s_busy), .mem_req (s_req), .memory_address (s_addr),
    .write_data_array (s_wda), .fill_word_index (s_idx), .fill_data (s_fd),
    .write_tag_array (s_wta), .fill_base (s_base)
  );

  assign o_busy = sel ? s_busy : b_busy;
  assign o_req  = sel ? s_req  : b_req;
  assign o_addr = sel ? s_addr : b_addr;
  assign o_wda  = sel ? s_wda  : b_wda;
  assign o_idx  = sel ? {1'b0, s_idx} : b_idx;
  assign o_fd   = sel ? s_fd   : b_fd;
  assign o_wta  = sel ? s_wta  : b_wta;
  assign o_base = sel ? s_base : b_base;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_req"},  o_req,  0);
    check({tag, "_wda"},  o_wda,  0);
    check({tag, "_wta"},  o_wta,  0);
    check({tag, "_addr"}, o_addr, 0);
    check({tag, "_idx"},  o_idx,  0);
    check({tag, "_base"}, o_base, 0);
  endtask

  // rmode: 0 ready always, 1 ready on odd cycles, 2 random.
  // rst_after > 0: assert reset once that many words have been written.
  task automatic run_fill(input logic s, input logic [15:0] addr, input int lat,
                          input int rmode, input int exp_busy, input bit pulse,
                          input int rst_after);
    int n, so, nreq, nwr, ntag, nbusy;
    bit done, exp_b;
    logic [15:0] base, cur;
    logic [15:0] exp_a[$];
    int          exp_i[$];
    int          due_q[$];
    logic [15:0] dat_q[$];

    n = s ? 4 : 8;
    base = addr & ~16'(2 * n - 1);
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
    so = (int'(addr) / 2) % n;
`else
    so = 0;
`endif
    for (int i = 0; i < n; i++) begin
      exp_a.push_back(base + 16'(((so + i) % n) * 2));
      exp_i.push_back((so + i) % n);
    end
    nreq = 0; nwr = 0; ntag = 0; nbusy = 0; done = 0; cur = '0;

    sel = s;
    @(posedge clk); #1;
    miss = 1'b1; maddr = addr; ready = 1'b0; valid = 1'b0;
    @(negedge clk);
    check("idle_before_miss", o_busy, 0);

    for (int cyc = 1; cyc < 300 && !done; cyc++) begin
      @(posedge clk); #1;
      miss  = pulse && (cyc == 3);
      maddr = (pulse && cyc == 3) ? 16'h4000 : addr;
      case (rmode)
        0:       ready = 1'b1;
        1:       ready = cyc[0];
        default: ready = 1'($urandom);
      endcase
      if (due_q.size() > 0 && due_q[0] <= cyc) begin
        valid = 1'b1;
        cur   = dat_q.pop_front();
        mdata = cur;
        void'(due_q.pop_front());
      end else begin
        valid = 1'b0;
        mdata = 16'($urandom);
      end
      @(negedge clk);
      exp_b = (ntag == 0);
      if (o_busy) nbusy++;
      check("busy", o_busy, exp_b);
      check("mem_req", o_req, exp_b && (nreq < n));
      check("wr_strobe", o_wda, valid && exp_b);
      check("tag_strobe", o_wta, exp_b && (nwr == n));
      if (o_req && ready) begin
        if (nreq < n) check("req_addr", o_addr, exp_a[nreq]);
        due_q.push_back(cyc + lat);
        dat_q.push_back(16'($urandom));
        nreq++;
      end
      if (o_wda) begin
        if (nwr < n) check("wr_index", o_idx, exp_i[nwr]);
        check("fill_data", o_fd, cur);
        nwr++;
      end
      if (o_wta) begin
        check("tag_base", o_base, base);
        ntag++;
      end
      if (!exp_b) done = 1;
      if (rst_after > 0 && nwr == rst_after) begin
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        valid = 1'b0; miss = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        valid = 1'b1; mdata = 16'hBEEF;
        @(negedge clk);
        check("stale_valid_wr", o_wda, 0);
        check("stale_valid_tag", o_wta, 0);
        check("stale_valid_busy", o_busy, 0);
        @(posedge clk); #1;
        valid = 1'b0;
        return;
      end
    end
    if (!done) check("fill_timeout", 0, 1);
    check("req_count", nreq, n);
    check("wr_count", nwr, n);
    check("tag_count", ntag, 1);
    if (exp_busy >= 0) check("busy_cycles", nbusy, exp_busy);
    check("base_held", o_base, base);

    @(posedge clk); #1;
    valid = 1'b1; mdata = 16'h5A5A;
    @(negedge clk);
    check("idle_valid_wr", o_wda, 0);
    check("idle_valid_busy", o_busy, 0);
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check_all_zero("in_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("after_reset");

    run_fill(1'b0, 16'h1234, 2, 0, 11, 1'b0, 0);
    run_fill(1'b0, 16'h1234, 1, 1, -1, 1'b1, 0);
    run_fill(1'b0, 16'h1234, 2, 0, -1, 1'b0, 3);
    run_fill(1'b0, 16'h0010, 2, 0, 11, 1'b0, 0);
    run_fill(1'b1, 16'hFFFE, 1, 0, 6, 1'b0, 0);
    for (int k = 0; k < 6; k++) begin
      run_fill(1'b0, 16'($urandom), int'($urandom_range(1, 4)), 2, -1, 1'b0, 0);
    end
    run_fill(1'b1, 16'($urandom), int'($urandom_range(1, 3)), 2, -1, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
